// File: rtl/led_matrix_scanner.sv
// Row-multiplexed scan driver for a 16x16 bicolor LED board, with a blanking gap before each row.
// The frame is snapshotted once per frame on the edge that enters DRIVE for row 0; outputs are registered.
module led_matrix_scanner #(
    parameter int DWELL_CYCLES = 1024,
    parameter int BLANK_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0][15:0] greenLED,
    input  logic [15:0][15:0] redLED,
    output logic [3:0]        row_addr,
    output logic              row_en,
    output logic [15:0]       green_col,
    output logic [15:0]       red_col,
    output logic              frame_start
);

    localparam int MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

    typedef enum logic {BLANK, DRIVE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [15:0][15:0] g_shadow;
    logic [15:0][15:0] r_shadow;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= BLANK;
            cnt         <= '0;
            row_addr    <= 4'd0;
            row_en      <= 1'b0;
            green_col   <= 16'h0000;
            red_col     <= 16'h0000;
            frame_start <= 1'b0;
            g_shadow    <= '0;
            r_shadow    <= '0;
        end else begin
            frame_start <= 1'b0;
            case (state)
                BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        state  <= DRIVE;
                        cnt    <= '0;
                        row_en <= 1'b1;
                        // Row 0 shows the freshly captured frame, so bypass the shadow for it.
                        if (row_addr == 4'd0) begin
                            g_shadow    <= greenLED;
                            r_shadow    <= redLED;
                            green_col   <= greenLED[0];
                            red_col     <= redLED[0];
                            frame_start <= 1'b1;
                        end else begin
                            green_col <= g_shadow[row_addr];
                            red_col   <= r_shadow[row_addr];
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DRIVE: begin
                    if (cnt == DWELL_LAST) begin
                        state     <= BLANK;
                        cnt       <= '0;
                        row_en    <= 1'b0;
                        green_col <= 16'h0000;
                        red_col   <= 16'h0000;
                        row_addr  <= row_addr + 4'd1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= BLANK;
            endcase
        end
    end

endmodule
